pos_axis_reg: RTL and testbench

Parametrised bounded position register with tick-paced stepping and hold-to-repeat. It replaces fixed-width single-step up/down position registers for player and object coordinates. Behaviour:
- Moves by a configurable step on frame ticks.
- Clamps or wraps at programmable bounds.
- Auto-repeats while a direction input is held.
- Supports a synchronous load.

---
 rtl/pos_pkg.sv | 29 ++
 rtl/pos_step_calc.sv | 64 ++++++
 rtl/pos_axis_reg.sv | 126 ++++++++++++
 tb/tb_pos_axis_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pos_pkg.sv
// Shared types and constants for the bounded position register family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pos_pkg;

  // Repeat state machine encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DELAY  = 2'd1;
  localparam state_t ST_REPEAT = 2'd2;

  // Decoded movement direction
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_NONE = 2'd0;
  localparam dir_t DIR_UP   = 2'd1;
  localparam dir_t DIR_DOWN = 2'd2;

  // Bound behaviour selector for the WRAP parameter
  localparam int MODE_CLAMP = 0;
  localparam int MODE_WRAP  = 1;

  // Repeat counter width: wide enough for max(delay, rate) - 1, never zero bits
  function automatic int cnt_width(input int delay_ticks, input int rate_ticks);
    int m;
    m = (delay_ticks > rate_ticks) ? delay_ticks : rate_ticks;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pos_step_calc.sv
// Next-position calculator: snap out-of-range pos, then clamp or wrap one step.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are stable.
module pos_step_calc
  import pos_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int STEP  = 1,
  parameter int WRAP  = MODE_CLAMP
) (
  input  logic [WIDTH-1:0] pos,
  input  dir_t             dir,
  input  logic [WIDTH-1:0] lower_bound,
  input  logic [WIDTH-1:0] upper_bound,
  output logic [WIDTH-1:0] next_pos,
  output logic             changed
);

  // One extra bit so pos+STEP and lower+STEP never overflow before comparison
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  logic [WIDTH:0] pos_x;
  logic [WIDTH:0] lo_x;
  logic [WIDTH:0] hi_x;
  logic [WIDTH:0] up_x;
  logic [WIDTH:0] next_x;

  assign pos_x = {1'b0, pos};
  assign lo_x  = {1'b0, lower_bound};
  assign hi_x  = {1'b0, upper_bound};
  assign up_x  = pos_x + STEP_X;

  // Snap first if bounds moved underneath pos, otherwise take one step
  always_comb begin
    next_x = pos_x;
    if (dir == DIR_UP || dir == DIR_DOWN) begin
      if (pos_x < lo_x) begin
        next_x = lo_x;
      end else if (pos_x > hi_x) begin
        next_x = hi_x;
      end else if (dir == DIR_UP) begin
        if (up_x <= hi_x)
          next_x = up_x;
        else if (WRAP == MODE_WRAP)
          next_x = lo_x + (up_x - hi_x - ONE_X);
        else
          next_x = hi_x;
      end else begin
        // pos >= lower+STEP is the underflow-free form of pos-STEP >= lower
        if (pos_x >= lo_x + STEP_X)
          next_x = pos_x - STEP_X;
        else if (WRAP == MODE_WRAP)
          next_x = hi_x - (lo_x + STEP_X - pos_x - ONE_X);
        else
          next_x = lo_x;
      end
    end
  end

  assign next_pos = next_x[WIDTH-1:0];
  assign changed  = (next_x != pos_x);

endmodule

// File: rtl/pos_axis_reg.sv
// Bounded position register with tick-paced stepping, hold-to-repeat and load.
// Latency: pos and moved update one clock after the sampling edge.
// Backpressure: none; inc/dec are levels, only sampled on tick cycles.
module pos_axis_reg
  import pos_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int STEP         = 1,
  parameter int WRAP         = MODE_CLAMP,
  parameter int INIT         = 0,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] lower_bound,
  input  logic [WIDTH-1:0] upper_bound,
  input  logic             tick,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pos,
  output logic             at_lower,
  output logic             at_upper,
  output logic             moved
);

  localparam int             CW         = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0]  DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]  RATE_LOAD  = CW'(REPEAT_RATE - 1);
  localparam logic [WIDTH-1:0] INIT_POS = WIDTH'(INIT);

  state_t          state;
  state_t          state_nxt;
  dir_t            dir;
  dir_t            last_dir;
  dir_t            last_dir_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            do_step;
  logic [WIDTH-1:0] step_pos;
  logic            step_changed;
  logic [WIDTH-1:0] load_pos;

  // Decode the level inputs; both pressed cancels out
  always_comb begin
    dir = DIR_NONE;
    if (inc && !dec)
      dir = DIR_UP;
    else if (dec && !inc)
      dir = DIR_DOWN;
  end

  pos_step_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .WRAP  (WRAP)
  ) u_step (
    .pos         (pos),
    .dir         (last_dir_nxt),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .next_pos    (step_pos),
    .changed     (step_changed)
  );

  // Loaded value is forced inside the current bounds
  always_comb begin
    load_pos = load_value;
    if (load_value < lower_bound)
      load_pos = lower_bound;
    else if (load_value > upper_bound)
      load_pos = upper_bound;
  end

  // Repeat FSM: first press steps at once, then waits DELAY, then steps every RATE
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_dir_nxt = last_dir;
    do_step      = 1'b0;
    if (tick) begin
      if (dir == DIR_NONE) begin
        state_nxt = ST_IDLE;
      end else if (state == ST_IDLE || dir != last_dir) begin
        do_step      = 1'b1;
        last_dir_nxt = dir;
        cnt_nxt      = DELAY_LOAD;
        state_nxt    = ST_DELAY;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
      end else begin
        do_step   = 1'b1;
        cnt_nxt   = RATE_LOAD;
        state_nxt = ST_REPEAT;
      end
    end
  end

  // State, position and moved pulse; load overrides any stepping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos      <= INIT_POS;
      state    <= ST_IDLE;
      cnt      <= '0;
      last_dir <= DIR_NONE;
      moved    <= 1'b0;
    end else if (load) begin
      pos      <= load_pos;
      state    <= ST_IDLE;
      moved    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_dir <= last_dir_nxt;
      moved    <= do_step && step_changed;
      if (do_step)
        pos <= step_pos;
    end
  end

  assign at_lower = (pos == lower_bound);
  assign at_upper = (pos == upper_bound);

endmodule

// File: tb/tb_pos_axis_reg.sv
// Directed bench: repeat timing, clamp/wrap, snap, load and async reset.
// Three instances: A default params with INIT=7, B clamp STEP=3, C wrap STEP=3.
module tb_pos_axis_reg;

  logic       clock;
  logic       reset;

  logic [6:0] a_lower, a_upper, a_load_value, a_pos;
  logic       a_tick, a_inc, a_dec, a_load, a_at_lower, a_at_upper, a_moved;

  logic [6:0] s_lower, s_upper, s_load_value, b_pos, c_pos;
  logic       s_tick, s_inc, s_dec, s_load;
  logic       b_at_lower, b_at_upper, b_moved, c_at_lower, c_at_upper, c_moved;

  int checks   = 0;
  int failures = 0;
  int exp_pos;
  int exp_m;

  pos_axis_reg #(.INIT(7)) dut_a (
    .clock(clock), .reset(reset), .lower_bound(a_lower), .upper_bound(a_upper),
    .tick(a_tick), .inc(a_inc), .dec(a_dec), .load(a_load), .load_value(a_load_value),
    .pos(a_pos), .at_lower(a_at_lower), .at_upper(a_at_upper), .moved(a_moved)
  );

  pos_axis_reg #(.STEP(3), .WRAP(0)) dut_b (
    .clock(clock), .reset(reset), .lower_bound(s_lower), .upper_bound(s_upper),
    .tick(s_tick), .inc(s_inc), .dec(s_dec), .load(s_load), .load_value(s_load_value),
    .pos(b_pos), .at_lower(b_at_lower), .at_upper(b_at_upper), .moved(b_moved)
  );

  pos_axis_reg #(.STEP(3), .WRAP(1)) dut_c (
    .clock(clock), .reset(reset), .lower_bound(s_lower), .upper_bound(s_upper),
    .tick(s_tick), .inc(s_inc), .dec(s_dec), .load(s_load), .load_value(s_load_value),
    .pos(c_pos), .at_lower(c_at_lower), .at_upper(c_at_upper), .moved(c_moved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_lower = 7'd0; a_upper = 7'd100; a_tick = 0; a_inc = 0; a_dec = 0;
    a_load = 0; a_load_value = 7'd0;
    s_lower = 7'd5; s_upper = 7'd20; s_tick = 0; s_inc = 0; s_dec = 0;
    s_load = 0; s_load_value = 7'd0;
    #2;
    check("rst_a_pos",      int'(a_pos), 7);
    check("rst_a_moved",    int'(a_moved), 0);
    check("rst_a_at_lower", int'(a_at_lower), 0);
    check("rst_b_pos",      int'(b_pos), 0);
    check("rst_b_at_lower", int'(b_at_lower), 0);
    @(negedge clock);
    reset = 1'b0;

    // A: load start position
    a_load = 1; a_load_value = 7'd10;
    cyc();
    check("a_load10_pos",   int'(a_pos), 10);
    check("a_load10_moved", int'(a_moved), 0);
    a_load = 0;

    // A: inc held 9 ticks -> steps on ticks 0,4,6,8
    a_inc = 1; a_tick = 1;
    exp_pos = 10;
    for (int k = 0; k < 9; k++) begin
      cyc();
      exp_m = (k == 0 || k == 4 || k == 6 || k == 8) ? 1 : 0;
      exp_pos = exp_pos + exp_m;
      check("rpt_moved", int'(a_moved), exp_m);
      check("rpt_pos",   int'(a_pos), exp_pos);
    end
    check("rpt_final_pos", int'(a_pos), 14);
    a_inc = 0;
    cyc();
    check("rpt_release_moved", int'(a_moved), 0);
    check("rpt_release_pos",   int'(a_pos), 14);

    // A: new press, then inc&dec from DELAY, then dec released
    a_inc = 1;
    cyc();
    check("press_pos", int'(a_pos), 15);
    a_dec = 1;
    cyc();
    check("both_pos",   int'(a_pos), 15);
    check("both_moved", int'(a_moved), 0);
    a_dec = 0;
    cyc();
    check("release_dec_pos",   int'(a_pos), 16);
    check("release_dec_moved", int'(a_moved), 1);

    // A: non-tick cycles hold FSM and counter
    a_tick = 0;
    repeat (3) cyc();
    check("notick_pos",   int'(a_pos), 16);
    check("notick_moved", int'(a_moved), 0);
    a_tick = 1;
    repeat (3) cyc();
    check("delay_count_pos", int'(a_pos), 16);
    cyc();
    check("delay_end_pos",   int'(a_pos), 17);
    check("delay_end_moved", int'(a_moved), 1);

    // A: load 120 with inc tick -> clamped 100, FSM back to IDLE
    a_load = 1; a_load_value = 7'd120;
    cyc();
    check("load_clamp_pos",   int'(a_pos), 100);
    check("load_clamp_moved", int'(a_moved), 0);
    check("load_at_upper",    int'(a_at_upper), 1);
    a_load = 0;
    a_upper = 7'd110;
    cyc();
    check("load_idle_pos",   int'(a_pos), 101);
    check("load_idle_moved", int'(a_moved), 1);

    // A: bound shrinks under pos, a step snaps to it
    a_upper = 7'd100; a_inc = 0; a_dec = 1;
    #1;
    check("oob_at_upper", int'(a_at_upper), 0);
    cyc();
    check("snap_pos",   int'(a_pos), 100);
    check("snap_moved", int'(a_moved), 1);
    repeat (3) cyc();
    check("snap_delay_pos", int'(a_pos), 100);
    cyc();
    check("repeat_entry_pos", int'(a_pos), 99);
    cyc();
    check("repeat_wait_pos", int'(a_pos), 99);

    // A: reset mid-REPEAT acts without a clock edge
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_pos",   int'(a_pos), 7);
    check("async_rst_moved", int'(a_moved), 0);
    cyc();
    check("rst_hold_pos", int'(a_pos), 7);
    @(negedge clock);
    reset = 1'b0; a_tick = 0;
    cyc();
    check("rel_nostep_pos",   int'(a_pos), 7);
    check("rel_nostep_moved", int'(a_moved), 0);
    a_tick = 1;
    cyc();
    check("post_rst_step_pos", int'(a_pos), 6);
    a_tick = 0; a_dec = 0;

    // B clamp / C wrap, STEP=3, bounds 5..20
    s_load = 1; s_load_value = 7'd19;
    cyc();
    check("bc_load_b", int'(b_pos), 19);
    check("bc_load_c", int'(c_pos), 19);
    s_load = 0; s_inc = 1; s_tick = 1;
    cyc();
    check("clamp_up_b_pos",   int'(b_pos), 20);
    check("clamp_up_b_moved", int'(b_moved), 1);
    check("wrap_up_c_pos",    int'(c_pos), 6);
    check("wrap_up_c_moved",  int'(c_moved), 1);
    cyc();
    check("clamp_hold_b_pos",   int'(b_pos), 20);
    check("clamp_hold_b_moved", int'(b_moved), 0);
    check("clamp_hold_at_upper", int'(b_at_upper), 1);
    check("wrap_hold_c_pos",    int'(c_pos), 6);
    s_inc = 0;
    cyc();
    s_dec = 1;
    cyc();
    check("clamp_dn_b_pos", int'(b_pos), 17);
    check("wrap_dn_c_pos",  int'(c_pos), 19);
    check("wrap_dn_c_moved", int'(c_moved), 1);
    s_dec = 0; s_load = 1; s_load_value = 7'd6;
    cyc();
    s_load = 0; s_dec = 1;
    cyc();
    check("clamp_lo_b_pos",   int'(b_pos), 5);
    check("clamp_lo_b_moved", int'(b_moved), 1);
    check("clamp_lo_at_lower", int'(b_at_lower), 1);
    check("wrap_lo_c_pos",    int'(c_pos), 19);
    s_dec = 0;
    cyc();
    s_dec = 1;
    cyc();
    check("clamp_atlo_b_pos",   int'(b_pos), 5);
    check("clamp_atlo_b_moved", int'(b_moved), 0);
    check("wrap_dn2_c_pos",     int'(c_pos), 16);
    s_dec = 0; s_load = 1; s_load_value = 7'd2;
    cyc();
    check("load_lo_b_pos", int'(b_pos), 5);
    check("load_lo_c_pos", int'(c_pos), 5);

    // Bounds 0..20: clamp must not underflow below zero
    s_lower = 7'd0; s_load_value = 7'd1;
    cyc();
    s_load = 0; s_dec = 1;
    cyc();
    check("no_underflow_b_pos", int'(b_pos), 0);
    check("wrap_zero_c_pos",    int'(c_pos), 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
